cu_wb: RTL and testbench

Writeback stage of the control unit, sitting downstream of the execute stage (CU_EX / ALU_top). It latches the destination tag issued by decode and waits for the execute result. It then consumes the result through a ready/taken handshake, writes the register file, and resolves branches into a PC update. An ALU error raises a sticky trap that blocks further retirement until cleared.

---
 rtl/cu_pkg.sv | 20 ++
 rtl/cu_wb.sv | 165 ++++++++++++++++
 tb/tb_cu_wb.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control-unit pipeline stages: the writeback FSM
// encoding, ALU flag bit positions and default datapath widths.
package cu_pkg;

    localparam int CU_XLEN   = 32;
    localparam int CU_REG_AW = 5;

    localparam int FLG_OVF  = 0;
    localparam int FLG_ZERO = 1;
    localparam int FLG_CON  = 2;
    localparam int FLG_ERR  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2,
        TRAP   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/cu_wb.sv
// Writeback stage: holds the decode tag, consumes one EX result per instruction,
// writes the register file, resolves branches and traps on ALU errors.
module cu_wb
    import cu_pkg::*;
#(
    parameter int XLEN   = CU_XLEN,
    parameter int REG_AW = CU_REG_AW
) (
    input  logic              soc_clk,
    input  logic              WB_reset_n,
    // Handshakes: a tag transfers on an edge where ctl_valid and ctl_ready are
    // both high; a result transfers on the WAIT edge that sees ex_result_ready,
    // and wb_result_taken pulses for exactly the following cycle. EX holds its
    // result until it sees that pulse.
    input  logic              ctl_valid,
    output logic              ctl_ready,
    input  logic [REG_AW-1:0] ctl_rd_addr,
    input  logic              ctl_rd_we,
    input  logic              ctl_is_branch,
    input  logic [XLEN-1:0]   ctl_branch_target,
    input  logic [XLEN-1:0]   ctl_pc_plus4,
    input  logic [XLEN-1:0]   ex_result_data,
    input  logic              ex_result_ready,
    input  logic              ex_overflow,
    input  logic              ex_zero,
    input  logic              ex_con_met,
    input  logic              ex_err,
    output logic              wb_result_taken,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              pc_load,
    output logic [XLEN-1:0]   pc_next,
    output logic [3:0]        last_flags,
    output logic              trap,
    input  logic              trap_clear,
    output logic [31:0]       retire_count,
    input  logic              dbg_retire_load,
    input  logic [31:0]       dbg_retire_value,
    output logic [1:0]        dbg_state
);

    wb_state_t         r_state;
    wb_state_t         w_state_nxt;

    logic [REG_AW-1:0] r_tag_rd_addr;
    logic              r_tag_rd_we;
    logic              r_tag_is_branch;
    logic [XLEN-1:0]   r_tag_target;
    logic [XLEN-1:0]   r_tag_pc_plus4;

    logic              r_ctl_ready;
    logic              r_taken;
    logic              r_rf_we;
    logic [REG_AW-1:0] r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;
    logic              r_pc_load;
    logic [XLEN-1:0]   r_pc_next;
    logic [3:0]        r_last_flags;
    logic              r_trap;
    logic [31:0]       r_retire_count;

    logic              w_accept;
    logic              w_capture;
    logic              w_commit;
    logic [3:0]        w_flags;

    // r_ctl_ready is low for the first cycle out of reset, so acceptance waits on it.
    assign w_accept  = (r_state == IDLE) && r_ctl_ready && ctl_valid;
    assign w_capture = (r_state == WAIT) && ex_result_ready;
    assign w_commit  = w_capture && !ex_err;

    always_comb begin
        w_flags           = '0;
        w_flags[FLG_OVF]  = ex_overflow;
        w_flags[FLG_ZERO] = ex_zero;
        w_flags[FLG_CON]  = ex_con_met;
        w_flags[FLG_ERR]  = ex_err;
    end

    always_ff @(posedge soc_clk or negedge WB_reset_n) begin
        if (!WB_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = WAIT;
            WAIT:    if (ex_result_ready) w_state_nxt = ex_err ? TRAP : COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            TRAP:    if (trap_clear) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge soc_clk or negedge WB_reset_n) begin
        if (!WB_reset_n) begin
            r_tag_rd_addr   <= '0;
            r_tag_rd_we     <= 1'b0;
            r_tag_is_branch <= 1'b0;
            r_tag_target    <= '0;
            r_tag_pc_plus4  <= '0;
        end else if (w_accept) begin
            r_tag_rd_addr   <= ctl_rd_addr;
            r_tag_rd_we     <= ctl_rd_we;
            r_tag_is_branch <= ctl_is_branch;
            r_tag_target    <= ctl_branch_target;
            r_tag_pc_plus4  <= ctl_pc_plus4;
        end
    end

    // Strobes are registered from the capture edge so they line up with COMMIT/TRAP.
    always_ff @(posedge soc_clk or negedge WB_reset_n) begin
        if (!WB_reset_n) begin
            r_ctl_ready    <= 1'b0;
            r_taken        <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_pc_load      <= 1'b0;
            r_pc_next      <= '0;
            r_last_flags   <= '0;
            r_trap         <= 1'b0;
            r_retire_count <= '0;
        end else begin
            r_ctl_ready <= (w_state_nxt == IDLE);
            r_trap      <= (w_state_nxt == TRAP);
            r_taken     <= w_capture;
            r_rf_we     <= w_commit && r_tag_rd_we && (r_tag_rd_addr != '0);
            r_pc_load   <= w_commit && r_tag_is_branch;
            if (w_capture) begin
                r_last_flags <= w_flags;
            end
            if (w_commit) begin
                r_rf_waddr <= r_tag_rd_addr;
                r_rf_wdata <= ex_result_data;
            end
            if (w_commit && r_tag_is_branch) begin
                r_pc_next <= ex_con_met ? r_tag_target : r_tag_pc_plus4;
            end
            if (dbg_retire_load) begin
                r_retire_count <= dbg_retire_value;
            end else if (w_commit) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign ctl_ready       = r_ctl_ready;
    assign wb_result_taken = r_taken;
    assign rf_we           = r_rf_we;
    assign rf_waddr        = r_rf_waddr;
    assign rf_wdata        = r_rf_wdata;
    assign pc_load         = r_pc_load;
    assign pc_next         = r_pc_next;
    assign last_flags      = r_last_flags;
    assign trap            = r_trap;
    assign retire_count    = r_retire_count;
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_cu_wb.sv
// Bench for cu_wb: directed and random instructions, expected results queued
// by a behavioural model and checked by a monitor on every taken pulse.
`timescale 1ns/1ps
module tb_cu_wb;
    import cu_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int W      = 108;

    logic              soc_clk;
    logic              WB_reset_n;
    logic              ctl_valid;
    logic              ctl_ready;
    logic [REG_AW-1:0] ctl_rd_addr;
    logic              ctl_rd_we;
    logic              ctl_is_branch;
    logic [XLEN-1:0]   ctl_branch_target;
    logic [XLEN-1:0]   ctl_pc_plus4;
    logic [XLEN-1:0]   ex_result_data;
    logic              ex_result_ready;
    logic              ex_overflow;
    logic              ex_zero;
    logic              ex_con_met;
    logic              ex_err;
    logic              wb_result_taken;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              pc_load;
    logic [XLEN-1:0]   pc_next;
    logic [3:0]        last_flags;
    logic              trap;
    logic              trap_clear;
    logic [31:0]       retire_count;
    logic              dbg_retire_load;
    logic [31:0]       dbg_retire_value;
    logic [1:0]        dbg_state;

    cu_wb #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .soc_clk           (soc_clk),
        .WB_reset_n        (WB_reset_n),
        .ctl_valid         (ctl_valid),
        .ctl_ready         (ctl_ready),
        .ctl_rd_addr       (ctl_rd_addr),
        .ctl_rd_we         (ctl_rd_we),
        .ctl_is_branch     (ctl_is_branch),
        .ctl_branch_target (ctl_branch_target),
        .ctl_pc_plus4      (ctl_pc_plus4),
        .ex_result_data    (ex_result_data),
        .ex_result_ready   (ex_result_ready),
        .ex_overflow       (ex_overflow),
        .ex_zero           (ex_zero),
        .ex_con_met        (ex_con_met),
        .ex_err            (ex_err),
        .wb_result_taken   (wb_result_taken),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .pc_load           (pc_load),
        .pc_next           (pc_next),
        .last_flags        (last_flags),
        .trap              (trap),
        .trap_clear        (trap_clear),
        .retire_count      (retire_count),
        .dbg_retire_load   (dbg_retire_load),
        .dbg_retire_value  (dbg_retire_value),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        soc_clk = 1'b0;
        forever #5 soc_clk = ~soc_clk;
    end

    int unsigned cyc = 0;
    always @(posedge soc_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int unsigned    vectors;
    int unsigned    miscompares;
    logic [W-1:0]   exp_q[$];
    logic [31:0]    m_retire;
    int unsigned    last_taken_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: what the stage must present for one instruction.
    task automatic push_expected(input logic [4:0] rd, input logic we, input logic br,
                                 input logic [31:0] tgt, input logic [31:0] pc4,
                                 input logic [31:0] data, input logic [3:0] flags);
        logic e_trap, e_we, e_pcl;
        logic [31:0] e_pc;
        e_trap = flags[3];
        e_we   = !e_trap && we && (rd != 0);
        e_pcl  = !e_trap && br;
        e_pc   = flags[2] ? tgt : pc4;
        if (!e_trap) m_retire = m_retire + 32'd1;
        exp_q.push_back({e_trap, e_we, e_pcl, rd, data, e_pc, m_retire, flags});
    endtask

    task automatic compare_result(input logic [W-1:0] e);
        logic        e_trap, e_we, e_pcl, ok;
        logic [4:0]  e_rd;
        logic [31:0] e_data, e_pc, e_ret;
        logic [3:0]  e_flags;
        {e_trap, e_we, e_pcl, e_rd, e_data, e_pc, e_ret, e_flags} = e;
        ok = (trap === e_trap) && (rf_we === e_we) && (pc_load === e_pcl) &&
             (retire_count === e_ret) && (last_flags === e_flags);
        if (e_we)  ok = ok && (rf_waddr === e_rd) && (rf_wdata === e_data);
        if (e_pcl) ok = ok && (pc_next === e_pc);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL result: got trap=%0b we=%0b waddr=%0d wdata=%08h pcl=%0b pc=%08h ret=%08h flg=%h expected trap=%0b we=%0b waddr=%0d wdata=%08h pcl=%0b pc=%08h ret=%08h flg=%h",
                     trap, rf_we, rf_waddr, rf_wdata, pc_load, pc_next, retire_count, last_flags,
                     e_trap, e_we, e_rd, e_data, e_pcl, e_pc, e_ret, e_flags);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge soc_clk);
            if (WB_reset_n) begin
                if (!wb_result_taken && (rf_we || pc_load)) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL strobe_without_taken: rf_we=%0b pc_load=%0b expected both 0", rf_we, pc_load);
                end
                if (wb_result_taken) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL spurious_taken: got taken=1 expected no pending result");
                    end else begin
                        compare_result(exp_q.pop_front());
                    end
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_result(input logic [31:0] data, input logic [3:0] flags);
        ex_result_data  = data;
        ex_overflow     = flags[0];
        ex_zero         = flags[1];
        ex_con_met      = flags[2];
        ex_err          = flags[3];
        ex_result_ready = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic br,
                         input logic [31:0] tgt, input logic [31:0] pc4,
                         input logic [31:0] data, input logic [3:0] flags,
                         input int delay, input bit push);
        bit accepted, got;
        int n;
        ctl_rd_addr       = rd;
        ctl_rd_we         = we;
        ctl_is_branch     = br;
        ctl_branch_target = tgt;
        ctl_pc_plus4      = pc4;
        ctl_valid         = 1'b1;
        if (delay == 0) set_result(data, flags);
        if (push) push_expected(rd, we, br, tgt, pc4, data, flags);
        accepted = 1'b0;
        n = 0;
        while (!accepted && n < 50) begin
            @(negedge soc_clk);
            if (ctl_ready) begin
                @(posedge soc_clk);
                accepted = 1'b1;
            end
            n++;
        end
        #1 ctl_valid = 1'b0;
        check("tag_accept", 32'(accepted), 32'd1);
        if (delay > 0) begin
            repeat (delay) @(negedge soc_clk);
            set_result(data, flags);
        end
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(posedge soc_clk);
            #1;
            if (wb_result_taken) got = 1'b1;
            n++;
        end
        ex_result_ready = 1'b0;
        last_taken_cyc  = cyc;
        check("result_taken", 32'(got), 32'd1);
    endtask

    task automatic clear_trap();
        @(negedge soc_clk);
        trap_clear = 1'b1;
        @(posedge soc_clk);
        #1 trap_clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned prev;
        logic [3:0]  fl;
        logic        rand_clear;

        vectors = 0; miscompares = 0; m_retire = 0;
        WB_reset_n = 1'b0;
        ctl_valid = 0; ctl_rd_addr = 0; ctl_rd_we = 0; ctl_is_branch = 0;
        ctl_branch_target = 0; ctl_pc_plus4 = 0;
        ex_result_data = 0; ex_result_ready = 0; ex_overflow = 0; ex_zero = 0;
        ex_con_met = 0; ex_err = 0; trap_clear = 0;
        dbg_retire_load = 0; dbg_retire_value = 0;

        repeat (3) @(negedge soc_clk);
        check("rst_ctl_ready", 32'(ctl_ready), 0);
        check("rst_taken", 32'(wb_result_taken), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_pc_load", 32'(pc_load), 0);
        check("rst_trap", 32'(trap), 0);
        check("rst_retire", retire_count, 0);
        check("rst_flags", 32'(last_flags), 0);
        WB_reset_n = 1'b1;
        @(posedge soc_clk);
        #1;
        check("post_rst_ready", 32'(ctl_ready), 1);
        check("post_rst_state", 32'(dbg_state), 32'(IDLE));

        fork
            monitor();
        join_none

        // Plain op, rd=0 suppression, branches taken / not taken, overflow.
        issue(5'd5, 1, 0, 32'h0, 32'h0, 32'h0000_1234, 4'b0000, 2, 1);
        issue(5'd0, 1, 0, 32'h0, 32'h0, 32'hDEAD_BEEF, 4'b0000, 1, 1);
        issue(5'd0, 0, 1, 32'h100, 32'h48, 32'h0000_0001, 4'b0100, 1, 1);
        issue(5'd9, 1, 1, 32'h100, 32'h48, 32'h0000_0000, 4'b0010, 3, 1);
        issue(5'd4, 1, 0, 32'h0, 32'h0, 32'h8000_0000, 4'b0001, 0, 1);
        check("retire_after_5", retire_count, 32'd5);

        // ALU error: sticky trap, then clear together with an ignored ctl_valid.
        issue(5'd3, 1, 0, 32'h0, 32'h0, 32'h0000_0055, 4'b1000, 1, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge soc_clk);
            check("trap_held", 32'(trap), 1);
            check("trap_not_ready", 32'(ctl_ready), 0);
        end
        @(negedge soc_clk);
        trap_clear = 1'b1; ctl_valid = 1'b1; ctl_rd_addr = 5'd7; ctl_rd_we = 1'b1;
        @(posedge soc_clk);
        #1 trap_clear = 1'b0; ctl_valid = 1'b0;
        check("trap_cleared", 32'(trap), 0);
        check("clear_ignores_valid", 32'(dbg_state), 32'(IDLE));
        check("clear_ready", 32'(ctl_ready), 1);
        issue(5'd6, 1, 0, 32'h0, 32'h0, 32'h0000_0777, 4'b0000, 2, 1);

        // Back-to-back with early ready, counter preset to wrap.
        @(negedge soc_clk);
        dbg_retire_load = 1'b1; dbg_retire_value = 32'hFFFF_FFFF;
        @(posedge soc_clk);
        #1 dbg_retire_load = 1'b0;
        m_retire = 32'hFFFF_FFFF;
        check("preset", retire_count, 32'hFFFF_FFFF);
        issue(5'd1, 1, 0, 32'h0, 32'h0, 32'h1111_1111, 4'b0000, 0, 1);
        check("wrap", retire_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            prev = last_taken_cyc;
            issue(5'(i + 10), 1, 0, 32'h0, 32'h0, $urandom, 4'b0000, 0, 1);
            check("cadence", last_taken_cyc - prev, 32'd3);
        end

        // Random instruction mix.
        for (int i = 0; i < 40; i++) begin
            fl = 4'($urandom_range(0, 7));
            fl[3] = ($urandom_range(0, 7) == 0);
            rand_clear = !fl[3] && ($urandom_range(0, 3) == 0);
            trap_clear = rand_clear;
            issue(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom} & 32'hFFFF_FFFC, {$urandom} & 32'hFFFF_FFFC, $urandom, fl,
                  $urandom_range(0, 3), 1);
            trap_clear = 1'b0;
            if (fl[3]) begin
                repeat ($urandom_range(1, 4)) @(negedge soc_clk);
                check("rand_trap_held", 32'(trap), 1);
                clear_trap();
            end
        end

        // Asynchronous reset during COMMIT aborts the strobes immediately.
        issue(5'd6, 1, 1, 32'h200, 32'h60, 32'hCAFE_0000, 4'b0100, 0, 0);
        check("pre_abort_rf_we", 32'(rf_we), 1);
        check("pre_abort_pc_load", 32'(pc_load), 1);
        #1 WB_reset_n = 1'b0;
        #1;
        check("abort_rf_we", 32'(rf_we), 0);
        check("abort_pc_load", 32'(pc_load), 0);
        check("abort_taken", 32'(wb_result_taken), 0);
        repeat (2) @(negedge soc_clk);
        WB_reset_n = 1'b1;
        m_retire = 0;
        @(posedge soc_clk);
        #1;
        check("rel_ready", 32'(ctl_ready), 1);
        check("rel_state", 32'(dbg_state), 32'(IDLE));
        check("rel_retire", retire_count, 0);
        check("rel_pc_next", pc_next, 0);
        check("rel_rf_wdata", rf_wdata, 0);
        check("rel_flags", 32'(last_flags), 0);
        issue(5'd2, 1, 0, 32'h0, 32'h0, 32'h0000_00AB, 4'b0000, 1, 1);

        repeat (3) @(negedge soc_clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
